// File: rtl/mem_pkg.sv
// Shared line-memory constants and types, also used by the cache controllers.
package mem_pkg;

   localparam int MEM_LINE_W = 64;   // 4 x 16-bit words per line
   localparam int MEM_ADDR_W = 14;   // default line-address width
   localparam int CNT_W      = 4;    // wide enough for LATENCY up to 15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Counter load value for a given access latency (cycles from acceptance to rdy).
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_line_array.sv
// Backing-store array: single port, synchronous write, registered read.
// The read register is only loaded by a read, so a write never disturbs it.
module mem_line_array
   import mem_pkg::*;
#(
   parameter int    ADDR_W    = MEM_ADDR_W,
   parameter int    LINE_W    = MEM_LINE_W,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] mem_q [0:(2**ADDR_W)-1];
   logic [LINE_W-1:0] rdata_q;
   logic [LINE_W-1:0] rdata_d;

   // Array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en && wr) begin
         mem_q[addr] <= wdata;
      end
   end

   // Next read-register value: only a read access updates it.
   always_comb begin
      rdata_d = rdata_q;
      if (en && !wr) begin
         rdata_d = mem_q[addr];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Read data register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Line-memory responder: accepts one read/write at a time, completes it after
// a fixed latency and signals completion with a one-cycle rdy pulse.
module mem_line_responder
   import mem_pkg::*;
#(
   parameter int    ADDR_W    = MEM_ADDR_W,
   parameter int    LINE_W    = MEM_LINE_W,
   parameter int    LATENCY   = 4,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              re,
   input  logic              we,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rd_data,
   output logic              rdy,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD     = lat_load(LATENCY);
   localparam bit               SINGLE_CYCLE = (LATENCY == 32'sd1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;
   logic                commit_s;

   // Next-state logic; the commit fires on the transition into RESP and uses
   // the *_d request fields so a single-cycle build commits the fresh request.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      commit_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (re || we) begin
               op_d     = we ? OP_WR : OP_RD;   // write wins over read
               addr_d   = addr;
               wdata_d  = wdata;
               cnt_d    = CNT_LOAD;
               state_d  = SINGLE_CYCLE ? RESP : BUSY;
               commit_s = SINGLE_CYCLE;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d  = RESP;
               commit_s = 1'b1;
            end else begin
               state_d  = BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;   // a request seen here is picked up again in IDLE
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rdy_d  = (state_d == RESP);
      busy_d = (state_d != IDLE);
   end

   // State, latched request and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   mem_line_array #(
      .ADDR_W    (ADDR_W),
      .LINE_W    (LINE_W),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (commit_s),
      .wr    (op_d == OP_WR),
      .addr  (addr_d),
      .wdata (wdata_d),
      .rdata (rd_data)
   );

   assign rdy  = rdy_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a LATENCY=4 and a LATENCY=1 instance are
// driven with directed and random requests and checked against a line model.
module tb_mem_line_responder;

   logic        clk;
   logic        rst_n;
   logic [13:0] addr_s  [2];
   logic        re_s    [2];
   logic        we_s    [2];
   logic [63:0] wdata_s [2];
   logic [63:0] rd_s    [2];
   logic        rdy_s   [2];
   logic        busy_s  [2];

   int vectors    = 0;
   int miscompares = 0;

   // reference model: line contents keyed by instance*65536+addr, last read line
   logic [63:0] model_mem [int];
   logic [63:0] last_rd   [2];
   logic [13:0] written0  [$];
   logic [13:0] written1  [$];

   mem_line_responder #(.ADDR_W(14), .LINE_W(64), .LATENCY(4), .INIT_FILE("")) u_dut4 (
      .clk(clk), .rst_n(rst_n), .addr(addr_s[0]), .re(re_s[0]), .we(we_s[0]),
      .wdata(wdata_s[0]), .rd_data(rd_s[0]), .rdy(rdy_s[0]), .busy(busy_s[0]));

   mem_line_responder #(.ADDR_W(14), .LINE_W(64), .LATENCY(1), .INIT_FILE("")) u_dut1 (
      .clk(clk), .rst_n(rst_n), .addr(addr_s[1]), .re(re_s[1]), .we(we_s[1]),
      .wdata(wdata_s[1]), .rd_data(rd_s[1]), .rdy(rdy_s[1]), .busy(busy_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input int s);
      return (s == 0) ? 4 : 1;
   endfunction

   // One request held until rdy; checks the rdy position, busy and rd_data.
   task automatic do_req(input int s, input bit do_we, input bit do_re,
                         input logic [13:0] a, input logic [63:0] wd, input bit churn);
      int lat;
      lat = lat_of(s);
      @(negedge clk);
      addr_s[s] = a; we_s[s] = do_we; re_s[s] = do_re; wdata_s[s] = wd;
      for (int n = 0; n < lat; n++) begin
         @(posedge clk); #1;
         if (n == 0) chk("busy_accept", 64'(busy_s[s]), 64'd1);
         chk("rdy_timing", 64'(rdy_s[s]), 64'(n == lat - 1));
         if (churn && n == 0 && lat > 1) begin
            addr_s[s] = a ^ 14'h0025; re_s[s] = 1'b0; we_s[s] = 1'b0; wdata_s[s] = ~wd;
         end
      end
      if (do_we) begin
         model_mem[s * 65536 + int'(a)] = wd;
         if (s == 0) written0.push_back(a); else written1.push_back(a);
      end else begin
         last_rd[s] = model_mem[s * 65536 + int'(a)];
      end
      chk("rd_data", rd_s[s], last_rd[s]);
      chk("busy_resp", 64'(busy_s[s]), 64'd1);
      @(negedge clk);
      re_s[s] = 1'b0; we_s[s] = 1'b0; addr_s[s] = 14'($urandom);
      @(posedge clk); #1;
      chk("rdy_pulse_end", 64'(rdy_s[s]), 64'd0);
      chk("busy_end", 64'(busy_s[s]), 64'd0);
   endtask

   // Read held high through two completions: measures first and second rdy.
   task automatic held_gap(input int s, input logic [13:0] a);
      int cyc, t1, t2, lat;
      lat = lat_of(s);
      cyc = 0; t1 = -1; t2 = -1;
      @(negedge clk);
      addr_s[s] = a; re_s[s] = 1'b1; we_s[s] = 1'b0;
      while (cyc < 40 && t2 < 0) begin
         @(posedge clk); #1;
         cyc++;
         if (rdy_s[s]) begin
            if (t1 < 0) t1 = cyc; else t2 = cyc;
         end
      end
      last_rd[s] = model_mem[s * 65536 + int'(a)];
      chk("held_first_rdy", 64'(t1), 64'(lat));
      chk("held_gap", 64'(t2 - t1), 64'(lat + 1));
      chk("held_rd_data", rd_s[s], last_rd[s]);
      @(negedge clk);
      re_s[s] = 1'b0;
      @(posedge clk); #1;
      chk("held_idle", 64'(busy_s[s]), 64'd0);
   endtask

   initial begin
      logic [13:0] ra;
      int          s;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         addr_s[i] = 14'd0; re_s[i] = 1'b0; we_s[i] = 1'b0; wdata_s[i] = 64'd0;
         last_rd[i] = 64'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_rdy", 64'(rdy_s[i]), 64'd0);
         chk("reset_busy", 64'(busy_s[i]), 64'd0);
         chk("reset_rd_data", rd_s[i], 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // directed steps on the LATENCY=4 instance
      do_req(0, 1'b1, 1'b0, 14'h0005, 64'h4444_3333_2222_1111, 1'b0);
      do_req(0, 1'b0, 1'b1, 14'h0005, 64'd0, 1'b0);
      do_req(0, 1'b1, 1'b0, 14'h3FFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      do_req(0, 1'b0, 1'b1, 14'h3FFF, 64'd0, 1'b0);
      do_req(0, 1'b1, 1'b1, 14'h0010, 64'h1, 1'b0);
      do_req(0, 1'b0, 1'b1, 14'h0010, 64'd0, 1'b0);
      do_req(0, 1'b1, 1'b0, 14'h0020, 64'h2020_2020_2020_2020, 1'b0);
      do_req(0, 1'b0, 1'b1, 14'h0005, 64'd0, 1'b1);
      held_gap(0, 14'h0005);

      // reset in the middle of a write: array keeps its old line
      do_req(0, 1'b1, 1'b0, 14'h0007, 64'hAA, 1'b0);
      @(negedge clk);
      addr_s[0] = 14'h0007; we_s[0] = 1'b1; wdata_s[0] = 64'hBB;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      we_s[0] = 1'b0;
      #1;
      chk("midop_rdy", 64'(rdy_s[0]), 64'd0);
      chk("midop_busy", 64'(busy_s[0]), 64'd0);
      last_rd[0] = 64'd0; last_rd[1] = 64'd0;
      chk("midop_rd_clear", rd_s[0], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(0, 1'b0, 1'b1, 14'h0007, 64'd0, 1'b0);

      // reset while rdy is high: rdy must drop without waiting for a clock
      @(negedge clk);
      addr_s[0] = 14'h0005; re_s[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("resp_rdy_before", 64'(rdy_s[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("resp_rdy_async", 64'(rdy_s[0]), 64'd0);
      chk("resp_busy_async", 64'(busy_s[0]), 64'd0);
      re_s[0] = 1'b0;
      last_rd[0] = 64'd0; last_rd[1] = 64'd0;
      @(negedge clk);
      rst_n = 1'b1;

      // LATENCY=1 instance
      do_req(1, 1'b1, 1'b0, 14'h0005, 64'h0123_4567_89AB_CDEF, 1'b0);
      do_req(1, 1'b0, 1'b1, 14'h0005, 64'd0, 1'b0);
      held_gap(1, 14'h0005);

      // random traffic on both instances
      for (int i = 0; i < 80; i++) begin
         s = i % 2;
         if ($urandom_range(0, 1) == 0 || (s == 0 && written0.size() == 0) ||
             (s == 1 && written1.size() == 0)) begin
            ra = 14'($urandom);
            do_req(s, 1'b1, 1'($urandom_range(0, 1)), ra,
                   {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
         end else begin
            if (s == 0) ra = written0[$urandom_range(0, written0.size() - 1)];
            else        ra = written1[$urandom_range(0, written1.size() - 1)];
            do_req(s, 1'b0, 1'b1, ra, 64'd0, 1'($urandom_range(0, 1)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
